// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-port
// memory with registered read data (Data_out valid one cycle after read_En).
// Only one memory command is in flight at a time: a write occupies IDLE+ISSUE
// (2 cycles), a read occupies IDLE+ISSUE+RD_RSP (3 cycles).
//
// Ports
//   Clk, rst                    clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A command (held until a_gnt)
//   a_gnt                       port A command accepted, 1-cycle pulse
//   a_rvalid/a_rdata            port A read response, 1-cycle valid pulse
//   b_*                         same set for port B
//   mem_Data_in/mem_Address     to memory
//   mem_write_En/mem_read_En    to memory
//   mem_Data_out                from memory
//
// Configuration
//   MEM_ARB_FIXED_PRIO_EN  when defined, A always wins contention and the
//                          round-robin history register is removed.
module mem_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] mem_Data_in,
  output logic [ADDR_W-1:0] mem_Address,
  output logic              mem_write_En,
  output logic              mem_read_En,
  input  logic [DATA_W-1:0] mem_Data_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RD_RSP = 2'd2;

  logic [1:0]        state;
  logic              win_b;
  logic              pick_b;
  logic              any_req;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  assign any_req = a_req | b_req;

  // Winner selection, only meaningful while in IDLE with a request present.
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_b = !a_req;
  end
`else
  logic last_b;

  // On contention the port that did not win last time is chosen.
  always_comb begin
    pick_b = b_req;
    if (a_req && b_req) begin
      pick_b = !last_b;
    end
  end

  // History starts at B so that A wins the first contention after reset.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      last_b <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_b <= pick_b;
    end
  end
`endif

  // Sequencer. Grant and enable strobes default low every cycle and are
  // only raised for the single cycle in which they apply. Address and write
  // data are left holding after a command so the memory pins stay quiet.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      win_b        <= 1'b0;
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      mem_Data_in  <= '0;
      mem_Address  <= '0;
      mem_write_En <= 1'b0;
      mem_read_En  <= 1'b0;
    end else begin
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      mem_write_En <= 1'b0;
      mem_read_En  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win_b        <= pick_b;
            a_gnt        <= !pick_b;
            b_gnt        <= pick_b;
            mem_write_En <= pick_b ? b_we : a_we;
            mem_read_En  <= pick_b ? !b_we : !a_we;
            mem_Address  <= pick_b ? b_addr : a_addr;
            mem_Data_in  <= pick_b ? b_wdata : a_wdata;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_read_En) begin
            a_rvalid <= !win_b;
            b_rvalid <= win_b;
            state    <= RD_RSP;
          end else begin
            state <= IDLE;
          end
        end
        RD_RSP: begin
          if (win_b) begin
            b_rdata_q <= mem_Data_out;
          end else begin
            a_rdata_q <= mem_Data_out;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // During the valid pulse the memory's registered output is forwarded
  // directly; afterwards the captured copy holds the value until the next
  // response for that port.
  assign a_rdata = a_rvalid ? mem_Data_out : a_rdata_q;
  assign b_rdata = b_rvalid ? mem_Data_out : b_rdata_q;

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 16x32 single-port memory (registered read data, one cycle after read_En).
- Sits between two master ports (A, B) and the memory pins. Drives the memory write_En/read_En/Address/Data_in from a small FSM.
- Returns read data to the winning requester with a one-cycle valid pulse.
- Only one memory command is in flight at any time.

Parameters:
- DATA_W, 32, data width; must match the memory data width.
- ADDR_W, 4, address width; the memory depth is 2**ADDR_W.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- a_req  input  1  port A request, level; held until a_gnt.
- a_we  input  1  port A command: 1 = write, 0 = read.
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_gnt  output  1  port A command accepted (1-cycle pulse).
- a_rvalid  output  1  port A read data valid (1-cycle pulse).
- a_rdata  output  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A set, for port B.
- mem_Data_in  output  DATA_W  to memory Data_in.
- mem_Address  output  ADDR_W  to memory Address.
- mem_write_En  output  1  to memory write_En.
- mem_read_En  output  1  to memory read_En.
- mem_Data_out  input  DATA_W  from memory Data_out.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; last_winner=B, so A wins the first contention.
- FSM states: IDLE, ISSUE, RD_RSP.
- IDLE, no req: stay in IDLE; mem_* enables 0.
- IDLE, req present:
  - Winner chosen. If only one requester is active, it wins. If both are active, the one that is not last_winner wins.
  - At the edge: capture the winner's we/addr/wdata into the mem_* output registers, set last_winner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_write_En=we, mem_read_En=!we, address and data stable.
  - Winner's gnt=1; the other gnt=0.
  - Next state: RD_RSP if read, IDLE if write.
  - Enables drop to 0 on exit.
- RD_RSP (1 cycle): winner's rvalid=1 and rdata=mem_Data_out, which now holds the memory output captured at the end of ISSUE. Then go to IDLE.
- Latency and throughput:
  - Write: req sampled in IDLE at cycle t; gnt and mem_write_En in cycle t+1. One write per 2 cycles.
  - Read: gnt in t+1, rvalid in t+2. One read per 3 cycles.
- Handshake rules:
  - The requester must keep req/we/addr/wdata stable until it sees gnt.
  - It must deassert req, or present a new command, by the edge that ends the gnt cycle.
  - The arbiter samples req only in IDLE, so a req still high during ISSUE or RD_RSP is never double-granted.
- Read data and unselected port:
  - x_rdata is registered and holds its last value between rvalid pulses.
  - The non-winning port's rdata is unchanged and its rvalid stays 0.
- Fairness: under continuous requests from both ports, grants strictly alternate A, B, A, B.
- Same address from both ports: commands execute in grant order. A read granted after a write to the same address returns the new data.
- Mid-operation reset: abort immediately and return to IDLE with outputs 0. A pending read response is dropped (no rvalid). A partially issued write is not retried.
- Widths: no arithmetic. Address and data are passed through without modification.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; A always wins contention and last_winner is unused. B is served only when a_req=0 in IDLE.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset: drive rst=0 mid-RD_RSP -> all outputs 0 asynchronously; after release, state IDLE, no rvalid pulse.
- A write then read:
  - A writes 0xDEADBEEF to addr 3 -> a_gnt and mem_write_En in the same cycle, 1 cycle after req.
  - A then reads addr 3 -> a_rvalid two cycles after req, a_rdata=0xDEADBEEF.
- Contention:
  - A and B both request reads of addr 5 (holding 0x11111111) from reset -> A granted first, then B. Each gets rvalid with 0x11111111; b_rvalid is never active together with a_rvalid.
  - Continuous requests from both ports for 8 grants -> order A, B, A, B, A, B, A, B.
- Same-address hazard: B writes 0x0000CAFE to addr 9 and A reads addr 9, both requesting in the same cycle right after a B grant (last_winner=B) -> A wins and reads the old value, then B writes. Next A read of addr 9 -> 0x0000CAFE.
- Held req: A keeps a_req=1 with an unchanged read across a_gnt -> exactly one grant per pass through IDLE, never two grants in consecutive cycles.
- With MEM_ARB_FIXED_PRIO_EN defined: both ports request continuously for 4 grants -> all 4 go to A. Drop a_req -> B is granted on the next IDLE.
